// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the 7-segment scan receiver.
// Segment patterns are {g,f,e,d,c,b,a} and active-low (0 = segment lit).
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Nibble reported for a blank digit and for any unrecognised pattern
    localparam logic [3:0] BLANK_NIB = 4'hF;

endpackage

// File: rtl/seg7_pattern_dec.sv
// seg7_pattern_dec: combinational segment pattern -> {BCD nibble, illegal flag}.
// Digits 0..9 decode to their value; blank decodes to BLANK_NIB without error;
// anything else decodes to BLANK_NIB with the error flag raised.
module seg7_pattern_dec
    import seg7_pkg::*;
(
    input  logic [6:0] iPattern,
    output logic [3:0] oNibble,
    output logic       oErr
);

    // Pattern lookup; default path flags the pattern as illegal
    always_comb begin
        oNibble = BLANK_NIB;
        oErr    = 1'b0;
        case (iPattern)
            SEG_0:     oNibble = 4'd0;
            SEG_1:     oNibble = 4'd1;
            SEG_2:     oNibble = 4'd2;
            SEG_3:     oNibble = 4'd3;
            SEG_4:     oNibble = 4'd4;
            SEG_5:     oNibble = 4'd5;
            SEG_6:     oNibble = 4'd6;
            SEG_7:     oNibble = 4'd7;
            SEG_8:     oNibble = 4'd8;
            SEG_9:     oNibble = 4'd9;
            SEG_BLANK: oNibble = BLANK_NIB;
            default:   oErr    = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_rx.sv
// seg7_scan_rx: receiver for a multiplexed 7-segment display bus.
// A digit is captured once its {select, segments} sample has been stable for
// STABLE_CYC consecutive cycles; when every slot has been captured the assembled
// frame is moved to the output register and offered on a valid/ready handshake.
// Optional feature: define SEG7_DP_EN to widen iSeg to 8 bits (bit 7 = decimal
// point, active-low) and add oDp with the captured decimal points (1 = lit).
module seg7_scan_rx
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 8,
    parameter int STABLE_CYC = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS-1:0]     iSel,
`ifdef SEG7_DP_EN
    input  logic [7:0]            iSeg,
`else
    input  logic [6:0]            iSeg,
`endif
    output logic [4*DIGITS-1:0]   oFrame,
    output logic [DIGITS-1:0]     oErr,
`ifdef SEG7_DP_EN
    output logic [DIGITS-1:0]     oDp,
`endif
    output logic                  oValid,
    input  logic                  iReady,
    output logic                  oOverrun
);

`ifdef SEG7_DP_EN
    localparam int SEG_W = 8;
`else
    localparam int SEG_W = 7;
`endif
    localparam int SMP_W = DIGITS + SEG_W;
    localparam int CNT_W = $clog2(STABLE_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CYC - 2);

    // Exactly one select line low
    function automatic logic legalSel(input logic [DIGITS-1:0] sel);
        logic [DIGITS-1:0] selN;
        selN = ~sel;
        return (selN != '0) && ((selN & (selN - DIGITS'(1))) == '0);
    endfunction

    logic [SMP_W-1:0]          sampleReg;
    logic [SMP_W-1:0]          curSample;
    logic [CNT_W-1:0]          cntReg;
    logic [CNT_W-1:0]          cntNext;
    logic                      stableHit;
    logic                      capture;
    logic [DIGITS-1:0]         capMask;
    logic [DIGITS-1:0]         seenReg;
    logic [DIGITS-1:0]         seenNext;
    logic                      frameDone;
    logic [3:0]                decNib;
    logic                      decErr;
    logic [DIGITS-1:0][3:0]    bufNib;
    logic [DIGITS-1:0]         bufErr;
`ifdef SEG7_DP_EN
    logic [DIGITS-1:0]         bufDp;
`endif

    assign curSample = {iSel, iSeg};

    // Previous-sample register; reset value has no select line low so it can never match
    always_ff @(posedge clk) begin
        if (rst) begin
            sampleReg <= '1;
        end else begin
            sampleReg <= curSample;
        end
    end

    // Stability counter next value and the single capture strobe per dwell
    always_comb begin
        stableHit = (curSample == sampleReg) && legalSel(iSel);
        cntNext   = '0;
        if (stableHit) begin
            cntNext = (cntReg == CNT_MAX) ? cntReg : cntReg + CNT_W'(1);
        end
        capture = stableHit && (cntReg == CNT_PRE);
        capMask = capture ? ~sampleReg[SEG_W +: DIGITS] : '0;
    end

    // Stability counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cntReg <= '0;
        end else begin
            cntReg <= cntNext;
        end
    end

    // Decode the registered segment pattern (equal to the live input whenever capture fires)
    seg7_pattern_dec uDec (
        .iPattern (sampleReg[6:0]),
        .oNibble  (decNib),
        .oErr     (decErr)
    );

    // Assembly buffer: one slot per digit, written when its select line captures
    for (genvar gi = 0; gi < DIGITS; gi++) begin : gSlot
        logic [3:0] nibReg;
        logic       errReg;
`ifdef SEG7_DP_EN
        logic       dpReg;
`endif

        // Slot storage, overwritten on every capture of this digit
        always_ff @(posedge clk) begin
            if (rst) begin
                nibReg <= '0;
                errReg <= 1'b0;
`ifdef SEG7_DP_EN
                dpReg  <= 1'b0;
`endif
            end else if (capMask[gi]) begin
                nibReg <= decNib;
                errReg <= decErr;
`ifdef SEG7_DP_EN
                dpReg  <= ~sampleReg[7];
`endif
            end
        end

        assign bufNib[gi] = nibReg;
        assign bufErr[gi] = errReg;
`ifdef SEG7_DP_EN
        assign bufDp[gi]  = dpReg;
`endif
    end

    // Seen mask: cleared when a full frame leaves the buffer, set by captures
    always_comb begin
        frameDone = &seenReg;
        seenNext  = (frameDone ? '0 : seenReg) | capMask;
    end

    // Seen mask register
    always_ff @(posedge clk) begin
        if (rst) begin
            seenReg <= '0;
        end else begin
            seenReg <= seenNext;
        end
    end

    // Output register and handshake; a completed frame is dropped if the previous one is still pending
    always_ff @(posedge clk) begin
        if (rst) begin
            oFrame   <= '0;
            oErr     <= '0;
            oValid   <= 1'b0;
            oOverrun <= 1'b0;
`ifdef SEG7_DP_EN
            oDp      <= '0;
`endif
        end else if (frameDone) begin
            if (!oValid || iReady) begin
                oFrame <= bufNib;
                oErr   <= bufErr;
                oValid <= 1'b1;
`ifdef SEG7_DP_EN
                oDp    <= bufDp;
`endif
            end else begin
                oOverrun <= 1'b1;
            end
        end else if (oValid && iReady) begin
            oValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg7_scan_rx.sv
// tb_seg7_scan_rx: directed-vector bench for seg7_scan_rx (DIGITS=8, STABLE_CYC=4).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_seg7_scan_rx;

    localparam int DIGITS     = 8;
    localparam int STABLE_CYC = 4;
`ifdef SEG7_DP_EN
    localparam int SEG_W = 8;
`else
    localparam int SEG_W = 7;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic [DIGITS-1:0]     iSel;
    logic [SEG_W-1:0]      iSeg;
    logic [4*DIGITS-1:0]   oFrame;
    logic [DIGITS-1:0]     oErr;
`ifdef SEG7_DP_EN
    logic [DIGITS-1:0]     oDp;
`endif
    logic                  oValid;
    logic                  iReady;
    logic                  oOverrun;

    int vecCnt = 0;
    int errCnt = 0;

    // Handshake monitor
    int                  acceptCnt = 0;
    logic [4*DIGITS-1:0] accFrame  = '0;
    logic [DIGITS-1:0]   accErr    = '0;

    // Segment patterns {g,f,e,d,c,b,a}, active-low, typed in from the digit table
    logic [6:0] segTab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    always #5 clk = ~clk;

    seg7_scan_rx #(
        .DIGITS     (DIGITS),
        .STABLE_CYC (STABLE_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .iSel     (iSel),
        .iSeg     (iSeg),
        .oFrame   (oFrame),
        .oErr     (oErr),
`ifdef SEG7_DP_EN
        .oDp      (oDp),
`endif
        .oValid   (oValid),
        .iReady   (iReady),
        .oOverrun (oOverrun)
    );

    always @(posedge clk) begin
        if (!rst && oValid && iReady) begin
            acceptCnt = acceptCnt + 1;
            accFrame  = oFrame;
            accErr    = oErr;
            $display("accept #%0d frame=%08h err=%02h", acceptCnt, oFrame, oErr);
        end
    end

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic idle(input int n);
        iSel = '1;
        iSeg = '1;
        repeat (n) @(negedge clk);
    endtask

    task automatic doReset(input int n);
        rst = 1'b1;
        iSel = '1;
        iSeg = '1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic showDigit(input int k, input logic [6:0] pat, input int dwell);
        logic [7:0] wide;
        wide = {1'b1, pat};
        iSel = '1;
        iSel[k] = 1'b0;
        iSeg = wide[SEG_W-1:0];
        repeat (dwell) @(negedge clk);
    endtask

    // Show every digit once; digit k displays nibble vals[4k+3:4k]
    task automatic scanWord(input logic [31:0] vals, input int dwell);
        for (int k = 0; k < DIGITS; k++) begin
            showDigit(k, segTab[vals[4*k +: 4]], dwell);
        end
    endtask

    initial begin
        int base;
        rst    = 1'b1;
        iReady = 1'b1;
        iSel   = '1;
        iSeg   = '1;
        @(negedge clk);

        // 1: reset state
        doReset(3);
        checkVal("rst oValid",   64'(oValid),   64'h0);
        checkVal("rst oFrame",   64'(oFrame),   64'h0);
        checkVal("rst oErr",     64'(oErr),     64'h0);
        checkVal("rst oOverrun", 64'(oOverrun), 64'h0);

        // 2: plain scan 01234567, minimum dwell
        base = acceptCnt;
        scanWord(32'h76543210, STABLE_CYC);
        idle(1);
        checkVal("t2 oValid up",  64'(oValid), 64'h1);
        checkVal("t2 oFrame",     64'(oFrame), 64'h76543210);
        checkVal("t2 oErr",       64'(oErr),   64'h0);
        idle(1);
        checkVal("t2 oValid down", 64'(oValid), 64'h0);
        checkVal("t2 accepts",    64'(acceptCnt - base), 64'h1);

        // 3: digit 2 one cycle short -> no frame; next scan completes the frame
        doReset(2);
        base = acceptCnt;
        for (int k = 0; k < DIGITS; k++) begin
            showDigit(k, segTab[k], (k == 2) ? STABLE_CYC - 1 : STABLE_CYC);
        end
        idle(3);
        checkVal("t3 short oValid", 64'(oValid), 64'h0);
        checkVal("t3 short accepts", 64'(acceptCnt - base), 64'h0);
        scanWord(32'h76543210, STABLE_CYC);
        idle(3);
        checkVal("t3 full accepts", 64'(acceptCnt - base), 64'h1);
        checkVal("t3 frame", 64'(accFrame), 64'h76543210);

        // 4: illegal pattern on digit 5, blank on digit 6
        doReset(2);
        base = acceptCnt;
        for (int k = 0; k < DIGITS; k++) begin
            if (k == 5)      showDigit(k, 7'b1111110, STABLE_CYC);
            else if (k == 6) showDigit(k, 7'b1111111, STABLE_CYC);
            else             showDigit(k, segTab[k], STABLE_CYC);
        end
        idle(3);
        checkVal("t4 accepts", 64'(acceptCnt - base), 64'h1);
        checkVal("t4 frame",   64'(accFrame), 64'h7FF43210);
        checkVal("t4 err",     64'(accErr),   64'h20);

        // 5: backpressure across two scans -> first frame held, overrun set
        doReset(2);
        iReady = 1'b0;
        base = acceptCnt;
        scanWord(32'h76543210, STABLE_CYC);
        idle(1);
        checkVal("t5 first oValid",   64'(oValid),   64'h1);
        checkVal("t5 first overrun",  64'(oOverrun), 64'h0);
        scanWord(32'h98989898, STABLE_CYC);
        idle(2);
        checkVal("t5 held oValid",  64'(oValid),   64'h1);
        checkVal("t5 held frame",   64'(oFrame),   64'h76543210);
        checkVal("t5 overrun",      64'(oOverrun), 64'h1);
        iReady = 1'b1;
        @(negedge clk);
        checkVal("t5 oValid drop",  64'(oValid), 64'h0);
        checkVal("t5 accepted",     64'(acceptCnt - base), 64'h1);
        checkVal("t5 acc frame",    64'(accFrame), 64'h76543210);
        idle(2);
        checkVal("t5 overrun sticky", 64'(oOverrun), 64'h1);

        // 6: reset mid-scan discards partial frame
        doReset(2);
        checkVal("t6 overrun cleared", 64'(oOverrun), 64'h0);
        base = acceptCnt;
        for (int k = 4; k < DIGITS; k++) begin
            showDigit(k, segTab[9], STABLE_CYC);
        end
        doReset(2);
        scanWord(32'h76543210, STABLE_CYC);
        idle(3);
        checkVal("t6 accepts", 64'(acceptCnt - base), 64'h1);
        checkVal("t6 frame",   64'(accFrame), 64'h76543210);
        checkVal("t6 err",     64'(accErr),   64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule
